// File: rtl/bcd_serial_adder_if.sv
// Purpose : operand/result bundle for the digit-serial packed-BCD adder.
// Ports   : master drives start/inA/inB/carryIn and observes busy/done/sum/carryOut/sumVal;
//           slave (the adder) is the mirror image. DIGITS sets operand width (4*DIGITS bits).
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   inA;
  logic [4*DIGITS-1:0]   inB;
  logic                  carryIn;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  carryOut;
  logic                  sumVal;

  modport master (
    output start, inA, inB, carryIn,
    input  busy, done, sum, carryOut, sumVal
  );

  modport slave (
    input  start, inA, inB, carryIn,
    output busy, done, sum, carryOut, sumVal
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Purpose : adds two DIGITS-wide packed-BCD operands, one digit per clock, LSD first.
// Latency : start accepted at edge k -> busy for DIGITS cycles -> done pulse after edge k+DIGITS.
// Backpr. : none; start is only honoured in IDLE, requests while busy are dropped (no queuing).
// Ports   : clk, rst_n (async active-low); bus (slave modport) carries start/operands/carryIn in,
//           busy/done/sum/carryOut/sumVal out. sum/carryOut/sumVal hold until the next completion.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_adder_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;       // operand shift registers, current digit in [3:0]
  logic [W-1:0]    res_q;          // partial result, filled digit by digit
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            vld_q;          // all digits seen so far were 0..9
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            sval_q;
  logic            done_q;

  logic            load, step, fin, busy;
  logic [3:0]      a_dig, b_dig, dig;
  logic [4:0]      raw;
  logic            carry_nx;
  logic            vld_nx;
  logic [W-1:0]    res_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    busy = 1'b0;
    case (state_q)
      IDLE: load = bus.start;
      ADD: begin
        step = 1'b1;
        busy = 1'b1;
        fin  = (cnt_q == LAST);
      end
      default: ;
    endcase
  end

  // One BCD digit: binary add, then +6 correction when the raw sum leaves 0..9.
  // Out-of-range inputs still go through the same rule; only the validity flag drops.
  always_comb begin
    a_dig    = a_q[3:0];
    b_dig    = b_q[3:0];
    raw      = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
    carry_nx = (raw > 5'd9);
    dig      = carry_nx ? (raw[3:0] + 4'd6) : raw[3:0];
    vld_nx   = vld_q & (a_dig <= 4'd9) & (b_dig <= 4'd9);
    res_nx   = res_q;
    res_nx[{cnt_q, 2'b00} +: 4] = dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        a_q     <= bus.inA;
        b_q     <= bus.inB;
        carry_q <= bus.carryIn;
        vld_q   <= 1'b1;
        cnt_q   <= '0;
        res_q   <= '0;
      end else if (step) begin
        a_q     <= a_q >> 4;
        b_q     <= b_q >> 4;
        carry_q <= carry_nx;
        vld_q   <= vld_nx;
        cnt_q   <= cnt_q + 1'b1;
        res_q   <= res_nx;
      end
      // Published results only change on the last digit, so no partial sum is ever visible.
      if (fin) begin
        sum_q  <= res_nx;
        cout_q <= carry_nx;
        sval_q <= vld_nx;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carryOut = cout_q;
  assign bus.sumVal   = sval_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Purpose : self-checking bench for bcd_serial_adder (DIGITS=4) with a done-driven scoreboard.
// Latency : expected done at the falling edge after edge k+DIGITS; checked per entry.
// Backpr. : none; the bench only drives start when the scenario calls for it.
module tb_bcd_serial_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(D)) bus ();

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         sval;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  logic [W-1:0] held_sum    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum",          32'(bus.sum),      32'(e.sum));
        check("carryOut",     32'(bus.carryOut), 32'(e.cout));
        check("sumVal",       32'(bus.sumVal),   32'(e.sval));
        check("done_latency", 32'(cyc),          32'(e.due));
        held_sum = e.sum;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic push, input logic [W-1:0] es, input logic ec,
                          input logic ev);
    exp_t e;
    @(negedge clk);
    bus.inA     = a;
    bus.inB     = b;
    bus.carryIn = c;
    bus.start   = 1'b1;
    if (push) begin
      e.sum = es; e.cout = ec; e.sval = ev; e.due = cyc + 1 + D;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    start_op(a, b, c, 1'b1, es, ec, ev);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check("busy",     32'(bus.busy), 32'd1);
      check("sum_held", 32'(bus.sum),  32'(held_sum));
    end
    @(negedge clk);
    #1;
    check("busy_clear", 32'(bus.busy), 32'd0);
    check("done_seen",  32'(sb.size()), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    #1 check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Independent decimal reference for valid operands.
  task automatic rand_add();
    logic [W-1:0] a, b, s;
    int av, bv, tot, p, lim;
    logic c;
    a = '0; b = '0; s = '0; av = 0; bv = 0; p = 1;
    for (int i = 0; i < D; i++) begin
      a[4*i +: 4] = 4'($urandom_range(0, 9));
      b[4*i +: 4] = 4'($urandom_range(0, 9));
      av += int'(a[4*i +: 4]) * p;
      bv += int'(b[4*i +: 4]) * p;
      p  *= 10;
    end
    lim = p;
    c   = 1'($urandom_range(0, 1));
    tot = av + bv + int'(c);
    p   = tot % lim;
    for (int i = 0; i < D; i++) begin
      s[4*i +: 4] = 4'(p % 10);
      p /= 10;
    end
    do_add(a, b, c, s, (tot >= lim), 1'b1);
  endtask

  initial begin
    bus.start = 1'b0; bus.inA = '0; bus.inB = '0; bus.carryIn = 1'b0;
    #12;
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_sum",      32'(bus.sum),      32'd0);
    check("rst_carryOut", 32'(bus.carryOut), 32'd0);
    check("rst_sumVal",   32'(bus.sumVal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero, correction and ripple cases
    do_add(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_add(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b1);
    do_add(16'h0007, 16'h0004, 1'b0, 16'h0011, 1'b0, 1'b1);
    do_add(16'h0006, 16'h0003, 1'b1, 16'h0010, 1'b0, 1'b1);
    do_add(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_add(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1);

    // Invalid digit, then validity re-armed
    do_add(16'h000A, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b0);
    do_add(16'h0002, 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b1);

    // Start while busy: second request and its operands are ignored
    start_op(16'h0123, 16'h0456, 1'b0, 1'b1, 16'h0579, 1'b0, 1'b1);
    @(negedge clk);
    start_op(16'h9999, 16'h9999, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    wait_drain("busy_ignore_drain");
    repeat (8) @(negedge clk);

    // Back-to-back: start held high, accepted every D+1 cycles
    @(negedge clk);
    bus.inA = 16'h0050; bus.inB = 16'h0050; bus.carryIn = 1'b0; bus.start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.sum = 16'h0100; e.cout = 1'b0; e.sval = 1'b1; e.due = cyc + 1 + D + (D + 1) * j;
      sb.push_back(e);
    end
    repeat (2 * (D + 1) + 1) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("b2b_drain");
    repeat (8) @(negedge clk);

    // Reset mid-operation
    start_op(16'h5555, 16'h1111, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus.busy),   32'd0);
    check("mid_rst_sum",    32'(bus.sum),    32'd0);
    check("mid_rst_sumVal", 32'(bus.sumVal), 32'd0);
    check("mid_rst_done",   32'(bus.done),   32'd0);
    held_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) rand_add();

    repeat (6) @(negedge clk);
    check("final_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder that sits directly upstream of the result registers and downstream of operand capture.
- Adds two DIGITS-wide packed-BCD operands one digit per clock, least-significant digit first.
- Carries between digits through a flip-flop.
- Reports the final carry, a validity flag for the operand digits, and a one-cycle completion pulse.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand/sum width = 4*DIGITS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request: capture operands and begin addition (honoured only when idle)
inA  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
inB  input  4*DIGITS  operand B, packed BCD
carryIn  input  1  carry into digit 0
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse: sum/carryOut/sumVal just updated
sum  output  4*DIGITS  packed-BCD result, held until next completion
carryOut  output  1  decimal carry out of the top digit
sumVal  output  1  1 = every digit of both captured operands was in 0..9

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, carryOut=0, sumVal=0.
  - Internal operand shift registers, carry flip-flop, digit counter and validity accumulator are cleared.
  - Any in-flight addition is abandoned; no done pulse follows.
- States: IDLE, ADD.
- IDLE, start=1 sampled at edge k:
  - Latch inA, inB; carry FF <= carryIn; valid accumulator <= 1; digit counter <= 0.
  - busy=1 from edge k.
  - start=0 in IDLE: no change.
- ADD, one digit per edge. At edge k+1+i (i = 0..DIGITS-1), process digit i:
  - raw = a_i + b_i + carry, 5-bit unsigned (max 15+15+1=31).
  - If raw > 9: digit = (raw + 6) mod 16, carry <= 1. Otherwise digit = raw[3:0], carry <= 0.
  - If a_i > 9 or b_i > 9: valid accumulator <= 0. The digit is still computed by the rule above; no error state.
  - Digit is shifted into the internal result register at position i.
- Completion, at edge k+DIGITS (the last digit edge):
  - sum <= full internal result (including digit DIGITS-1); carryOut <= final carry; sumVal <= valid accumulator.
  - done <= 1 for exactly one cycle; busy <= 0; state goes to IDLE.
- Latency: start sampled at edge k -> done high during cycle after edge k+DIGITS. busy high for exactly DIGITS cycles.
- start while busy: ignored, no queuing. inA/inB/carryIn changes while busy have no effect.
- start=1 during the done cycle: accepted (state is IDLE). busy rises at that edge, and done falls at the same edge.
- sum/carryOut/sumVal never show partial results; previous values hold throughout busy.
- DIGITS=1: busy for one cycle, then done.

Test Plan:
- Zero case: reset, start with inA=0000, inB=0000, carryIn=0 -> busy for 4 cycles; done pulse 4 edges after start; sum=0000, carryOut=0, sumVal=1.
- Correction and ripple:
  - 0005+0003, cin=0 -> sum=0008, carryOut=0, sumVal=1.
  - 0007+0004 -> sum=0011.
  - 0006+0003, cin=1 -> sum=0010.
  - 9999+0001 -> sum=0000, carryOut=1, sumVal=1.
- Invalid digit: inA=000A, inB=0001 -> sumVal=0, sum=0011 per the raw>9 rule, done still pulses on time. Next add 0002+0001 -> sum=0003, sumVal=1 (accumulator re-armed).
- Start while busy: start 0123+0456, pulse start with 9999+9999 two cycles later -> single done, sum=0579, carryOut=0. No second done.
- Back-to-back: hold start=1 continuously with 0050+0050 -> done every 5th cycle (4 busy + 1 done/accept cycle), sum=0100 each time.
- Reset mid-op: deassert rst_n two cycles after start -> busy=0, sum=0, sumVal=0 immediately (asynchronous), no done. After release, a fresh 1234+4321 -> sum=5555.
